// File: rtl/quiz_arbiter_pkg.sv
// quiz_pkg: shared definitions for the quiz arbiter.
//   NUM_PLAYERS  - number of player buttons
//   WINNER_W     - width of the BCD winner code
//   state_t      - arbiter state encoding
//   pick_player  - priority pick among simultaneous press events,
//                  searching upward from a base index with wrap-around
package quiz_pkg;

    localparam int unsigned NUM_PLAYERS = 4;
    localparam int unsigned WINNER_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FOUL    = 3'd4
    } state_t;

    function automatic logic [1:0] pick_player(input logic [NUM_PLAYERS-1:0] ev,
                                               input logic [1:0]             base);
        logic [1:0] sel;
        logic [1:0] idx;
        logic       found;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            idx = base + 2'(i);
            if (!found && ev[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/quiz_arbiter_key_filter.sv
// key_filter: qualifies one player key.
//   clock_1 - system clock (rising edge)
//   reset   - asynchronous active-low reset
//   key     - pre-synchronised active-high button
//   press   - one-cycle event, high while the HOLD_CYCLES-th consecutive
//             high sample is being taken (consumed on that same edge)
module key_filter
    import quiz_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic clock_1,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic [3:0] cnt;

    // Saturating run-length of high samples; saturation stops repeat events.
    always_ff @(posedge clock_1 or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!key) begin
            cnt <= '0;
        end else if (cnt != 4'(HOLD_CYCLES)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign press = key && (cnt == 4'(HOLD_CYCLES - 1));

endmodule

// File: rtl/quiz_arbiter.sv
// quiz_arbiter: quiz-show buzzer arbiter.
//   clock_1     - system clock (rising edge)
//   reset       - asynchronous active-low reset
//   start/clear - host control pulses
//   key[3:0]    - player buttons, bit i = player i+1
//   timeout     - countdown expired
//   C_en        - countdown enable (high while armed)
//   cnt_reset_n - one-cycle active-low countdown reload on arming
//   winner      - BCD player number, 0 = none
//   led         - one-hot winner/fouler indicator
//   foul        - early-press flag
//   buzz        - buzzer drive, BUZZ_CYCLES long
// Build option: QUIZ_ARBITER_RR_PRIORITY_EN selects rotating priority
// (default build uses fixed lowest-player-wins priority).
module quiz_arbiter
    import quiz_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned BUZZ_CYCLES = 4
) (
    input  logic                   clock_1,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear,
    input  logic [NUM_PLAYERS-1:0] key,
    input  logic                   timeout,
    output logic                   C_en,
    output logic                   cnt_reset_n,
    output logic [WINNER_W-1:0]    winner,
    output logic [NUM_PLAYERS-1:0] led,
    output logic                   foul,
    output logic                   buzz
);

    state_t                 state;
    state_t                 next_state;
    logic [NUM_PLAYERS-1:0] ev;
    logic                   any_press;
    logic [1:0]             sel;
    logic [1:0]             prio_base;
    logic                   arm_pulse;
    logic [15:0]            buzz_cnt;
    logic                   grab;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_kf
        key_filter #(.HOLD_CYCLES(HOLD_CYCLES)) u_kf (
            .clock_1 (clock_1),
            .reset   (reset),
            .key     (key[g]),
            .press   (ev[g])
        );
    end

    assign any_press = |ev;
    assign sel       = pick_player(ev, prio_base);

`ifdef QUIZ_ARBITER_RR_PRIORITY_EN
    // Only a won round moves the pointer; fouls leave it alone.
    always_ff @(posedge clock_1 or negedge reset) begin
        if (!reset) begin
            prio_base <= '0;
        end else if (state == ST_ARMED && next_state == ST_LOCKED) begin
            prio_base <= sel + 2'd1;
        end
    end
`else
    assign prio_base = '0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_ARMED;
                end else if (any_press) begin
                    next_state = ST_FOUL;
                end
            end
            ST_ARMED: begin
                // A press beats a timeout arriving on the same edge.
                if (any_press) begin
                    next_state = ST_LOCKED;
                end else if (timeout) begin
                    next_state = ST_TIMEOUT;
                end
            end
            default: next_state = state;
        endcase
        if (clear) begin
            next_state = ST_IDLE;
        end
    end

    assign grab = (next_state != state) &&
                  (next_state == ST_LOCKED || next_state == ST_FOUL);

    always_ff @(posedge clock_1 or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            C_en      <= 1'b0;
            arm_pulse <= 1'b0;
            winner    <= '0;
            led       <= '0;
            foul      <= 1'b0;
            buzz_cnt  <= '0;
        end else begin
            state     <= next_state;
            C_en      <= (next_state == ST_ARMED);
            arm_pulse <= (next_state == ST_ARMED) && (state != ST_ARMED);
            if (clear) begin
                winner   <= '0;
                led      <= '0;
                foul     <= 1'b0;
                buzz_cnt <= '0;
            end else if (grab) begin
                winner   <= WINNER_W'(sel) + WINNER_W'(1);
                led      <= NUM_PLAYERS'(1) << sel;
                foul     <= (next_state == ST_FOUL);
                buzz_cnt <= 16'(BUZZ_CYCLES);
            end else if (buzz_cnt != '0) begin
                buzz_cnt <= buzz_cnt - 16'd1;
            end
        end
    end

    assign cnt_reset_n = ~arm_pulse;
    assign buzz        = (buzz_cnt != '0);

endmodule

// File: tb/tb_quiz_arbiter.sv
// tb_quiz_arbiter: directed and random stimulus for quiz_arbiter,
// checked every cycle against a behavioural model of the game rules.
module tb_quiz_arbiter;

    localparam int HOLD = 2;
    localparam int BUZZ = 4;

    logic       clock_1 = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       clear   = 1'b0;
    logic       timeout = 1'b0;
    logic [3:0] key     = 4'b0000;
    logic       C_en;
    logic       cnt_reset_n;
    logic [3:0] winner;
    logic [3:0] led;
    logic       foul;
    logic       buzz;

    quiz_arbiter #(.HOLD_CYCLES(HOLD), .BUZZ_CYCLES(BUZZ)) dut (
        .clock_1     (clock_1),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .key         (key),
        .timeout     (timeout),
        .C_en        (C_en),
        .cnt_reset_n (cnt_reset_n),
        .winner      (winner),
        .led         (led),
        .foul        (foul),
        .buzz        (buzz)
    );

    always #5 clock_1 = ~clock_1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

`ifdef QUIZ_ARBITER_RR_PRIORITY_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Game model: mode 0 idle, 1 armed, 2 locked, 3 timed out, 4 fouled.
    int m_mode, m_win, m_foul, m_buzz, m_ptr, m_pulse;
    int run[4];

    function automatic void model_reset();
        m_mode = 0; m_win = 0; m_foul = 0; m_buzz = 0; m_ptr = 0; m_pulse = 0;
        for (int i = 0; i < 4; i++) run[i] = 0;
    endfunction

    function automatic void model_step();
        int pressed[$];
        int who;
        int prev;
        pressed.delete();
        for (int i = 0; i < 4; i++) begin
            if (key[i]) begin
                if (run[i] == HOLD - 1) pressed.push_back(i);
                if (run[i] < HOLD) run[i] = run[i] + 1;
            end else begin
                run[i] = 0;
            end
        end
        who = -1;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = (m_ptr + k) % 4;
            foreach (pressed[j]) if (who < 0 && pressed[j] == p) who = p;
        end
        prev = m_mode;
        if (m_buzz > 0) m_buzz = m_buzz - 1;
        if (clear) begin
            m_mode = 0; m_win = 0; m_foul = 0; m_buzz = 0;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
            else if (who >= 0) begin
                m_mode = 4; m_win = who + 1; m_foul = 1; m_buzz = BUZZ;
            end
        end else if (m_mode == 1) begin
            if (who >= 0) begin
                m_mode = 2; m_win = who + 1; m_foul = 0; m_buzz = BUZZ;
                if (RR) m_ptr = (who + 1) % 4;
            end else if (timeout) begin
                m_mode = 3;
            end
        end
        m_pulse = (m_mode == 1 && prev != 1) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock_1) if (reset) model_step();
    always @(negedge reset) model_reset();

    // Compare process: all outputs against the model, away from the clock edge.
    always @(negedge clock_1) begin
        if (chk_en) begin
            check("C_en", int'(C_en), (m_mode == 1) ? 1 : 0);
            check("cnt_reset_n", int'(cnt_reset_n), m_pulse ? 0 : 1);
            check("winner", int'(winner), m_win);
            check("led", int'(led), (m_win > 0) ? (1 << (m_win - 1)) : 0);
            check("foul", int'(foul), m_foul);
            check("buzz", int'(buzz), (m_buzz > 0) ? 1 : 0);
        end
    end

    // Drive inputs, then wait for the next edge plus settling time.
    task automatic cyc(input logic s, input logic c, input logic [3:0] k, input logic t);
        start = s; clear = c; key = k; timeout = t;
        @(posedge clock_1);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock_1);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        check("rst_C_en", int'(C_en), 0);
        check("rst_cnt_reset_n", int'(cnt_reset_n), 1);
        check("rst_winner", int'(winner), 0);
        check("rst_buzz", int'(buzz), 0);

        // Simultaneous presses, two rounds.
        cyc(1, 0, 4'b1010, 0);
        check("arm_C_en", int'(C_en), 1);
        check("arm_cnt_reset_n", int'(cnt_reset_n), 0);
        cyc(0, 0, 4'b1010, 0);
        check("r1_winner", int'(winner), 2);
        check("r1_led", int'(led), 4'b0010);
        cyc(0, 1, 4'b0000, 0);
        cyc(1, 0, 4'b1010, 0);
        cyc(0, 0, 4'b1010, 0);
        check("r2_winner", int'(winner), RR ? 4 : 2);
        cyc(0, 1, 4'b0000, 0);

        // Normal lock by player 3 with buzzer length.
        cyc(1, 0, 4'b0000, 0);
        cyc(0, 0, 4'b0100, 0);
        check("lock_not_yet", int'(winner), 0);
        cyc(0, 0, 4'b0100, 0);
        check("lock_winner", int'(winner), 3);
        check("lock_led", int'(led), 4'b0100);
        check("lock_C_en", int'(C_en), 0);
        check("lock_buzz_on", int'(buzz), 1);
        repeat (3) cyc(0, 0, 4'b0100, 0);
        check("buzz_last", int'(buzz), 1);
        cyc(0, 0, 4'b0100, 0);
        check("buzz_off", int'(buzz), 0);
        cyc(0, 1, 4'b0000, 0);

        // Early press fouls; start ignored afterwards.
        cyc(0, 0, 4'b0010, 0);
        cyc(0, 0, 4'b0010, 0);
        check("foul_flag", int'(foul), 1);
        check("foul_winner", int'(winner), 2);
        cyc(1, 0, 4'b0010, 0);
        check("foul_hold_C_en", int'(C_en), 0);
        cyc(0, 1, 4'b0000, 0);

        // Timeout, then clear and re-arm.
        cyc(1, 0, 4'b0000, 0);
        cyc(0, 0, 4'b0000, 1);
        check("to_C_en", int'(C_en), 0);
        check("to_winner", int'(winner), 0);
        cyc(0, 1, 4'b0000, 0);
        cyc(1, 0, 4'b0000, 0);
        check("rearm_C_en", int'(C_en), 1);

        // Single-cycle glitch ignored; press beats same-edge timeout.
        cyc(0, 0, 4'b0001, 0);
        cyc(0, 0, 4'b0000, 0);
        check("glitch_winner", int'(winner), 0);
        cyc(0, 0, 4'b0010, 0);
        cyc(0, 0, 4'b0010, 1);
        check("tie_to_winner", int'(winner), 2);
        cyc(0, 1, 4'b0000, 0);

        // Asynchronous reset while armed, key held across release.
        cyc(1, 0, 4'b0001, 0);
        reset = 1'b0;
        #1;
        check("async_C_en", int'(C_en), 0);
        check("async_cnt_reset_n", int'(cnt_reset_n), 1);
        repeat (2) cyc(0, 0, 4'b0001, 0);
        reset = 1'b1;
        cyc(0, 0, 4'b0001, 0);
        check("post_rst_wait", int'(winner), 0);
        cyc(0, 0, 4'b0001, 0);
        check("post_rst_foul", int'(winner), 1);
        cyc(0, 1, 4'b0000, 0);
        cyc(1, 1, 4'b0000, 0);
        check("clr_start_C_en", int'(C_en), 0);
        check("clr_start_pulse", int'(cnt_reset_n), 1);

        // Random play.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] k;
            k = key;
            if ($urandom_range(0, 3) == 0) k = 4'($urandom);
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), k,
                ($urandom_range(0, 11) == 0));
        end
        cyc(0, 1, 4'b0000, 0);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
